// File: rtl/config_frame_loader_if.sv
// Word-stream handshake between the bitstream front end and the frame loader.
interface config_frame_loader_if #(
   parameter int unsigned WORD_W = 32
);
   logic [WORD_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/config_frame_loader.sv
// Config frame loader: assembles {header, data words[, checksum]} packets into a
// frame, then drives frame_data and pulses one frame_strobe line with setup/hold
// margins so the fabric's transparent latches capture clean data.
// Optional feature macro: FRAME_CHECKSUM_EN (adds a trailing XOR checksum word).
module config_frame_loader #(
   parameter int unsigned WORD_W     = 32,
   parameter int unsigned FRAME_BITS = 32,
   parameter int unsigned NUM_FRAMES = 20,
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 2,
   parameter int unsigned HOLD_CYC   = 1
) (
   input  logic                  CLK,
   input  logic                  resetn,
   config_frame_loader_if.slave  stream,
   input  logic                  clr_err,
   output logic [FRAME_BITS-1:0] frame_data,
   output logic [NUM_FRAMES-1:0] frame_strobe,
   output logic                  busy,
   output logic                  err_sync,
   output logic                  err_addr,
   output logic                  err_chk,
   output logic [15:0]           frames_loaded
);

   localparam int unsigned NW = FRAME_BITS / WORD_W;
`ifdef FRAME_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif
   localparam int unsigned NWORDS = NW + (CHK_EN ? 1 : 0);
   localparam int unsigned WCW    = $clog2(NWORDS + 1);
   localparam int unsigned MAXC01 = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
   localparam int unsigned MAXC   = (MAXC01 > HOLD_CYC) ? MAXC01 : HOLD_CYC;
   localparam int unsigned CW     = $clog2(MAXC + 1);
   localparam logic [15:0] SYNC   = 16'hFAB0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      CHK    = 3'd2,
      SETUP  = 3'd3,
      STROBE = 3'd4,
      HOLD   = 3'd5
   } state_t;

   state_t                  state_q, state_next;
   logic [WCW-1:0]          wcnt_q;
   logic [CW-1:0]           cnt_q;
   logic [15:0]             idx_q;
   logic                    discard_q;
   logic                    ready_q;
   logic                    busy_q;
   logic [NUM_FRAMES-1:0]   strobe_q;
   logic [NUM_FRAMES-1:0]   strobe_sel;
   logic [FRAME_BITS-1:0]   data_q;
   logic [15:0]             loaded_q;
   logic                    err_sync_q;
   logic                    err_addr_q;
   logic                    err_chk_q;
   logic                    chk_bad_q;

   logic                    accept;
   logic                    hdr_ok;
   logic                    hdr_take;
   logic                    last_word;
   logic                    idx_bad;

   assign accept    = stream.s_valid & ready_q;
   assign hdr_ok    = (stream.s_data[31:16] == SYNC);
   assign hdr_take  = (state_q == IDLE) && accept && hdr_ok;
   assign last_word = (wcnt_q == WCW'(NWORDS - 1));
   assign idx_bad   = (stream.s_data[15:0] >= 16'(NUM_FRAMES));

   // State register.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state_q;
      case (state_q)
         IDLE:   if (accept && hdr_ok) state_next = LOAD;
         LOAD: begin
            if (accept && last_word) begin
               if (discard_q)   state_next = IDLE;
               else if (CHK_EN) state_next = CHK;
               else             state_next = SETUP;
            end
         end
         CHK:    state_next = chk_bad_q ? IDLE : SETUP;
         SETUP:  if (cnt_q == CW'(SETUP_CYC - 1))  state_next = STROBE;
         STROBE: if (cnt_q == CW'(STROBE_CYC - 1)) state_next = HOLD;
         HOLD:   if (cnt_q == CW'(HOLD_CYC - 1))   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // One-hot decode of the latched frame index (all zero when out of range).
   always_comb begin
      strobe_sel = '0;
      for (int i = 0; i < int'(NUM_FRAMES); i++) strobe_sel[i] = (idx_q == 16'(i));
   end

   // Dwell counter for the SETUP/STROBE/HOLD phases; restarts on every state change.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn)                                              cnt_q <= '0;
      else if (state_next != state_q)                           cnt_q <= '0;
      else if (state_q == SETUP || state_q == STROBE || state_q == HOLD) cnt_q <= cnt_q + CW'(1);
   end

   // Header capture and word counting within the packet.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         idx_q     <= '0;
         discard_q <= 1'b0;
         wcnt_q    <= '0;
      end else if (hdr_take) begin
         idx_q     <= stream.s_data[15:0];
         discard_q <= idx_bad;
         wcnt_q    <= '0;
      end else if (state_q == LOAD && accept) begin
         wcnt_q <= wcnt_q + WCW'(1);
      end
   end

   // Frame assembly: word k lands in slice k counted from the MSB end.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         data_q <= '0;
      end else if (state_q == LOAD && accept && !discard_q) begin
         for (int k = 0; k < int'(NW); k++) begin
            if (wcnt_q == WCW'(k)) data_q[FRAME_BITS-1-k*WORD_W -: WORD_W] <= stream.s_data;
         end
      end
   end

`ifdef FRAME_CHECKSUM_EN
   logic [WORD_W-1:0] acc_q;

   // Running XOR of data words; mismatch against the trailing word is flagged for CHK.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         acc_q     <= '0;
         chk_bad_q <= 1'b0;
      end else if (hdr_take) begin
         acc_q     <= '0;
         chk_bad_q <= 1'b0;
      end else if (state_q == LOAD && accept) begin
         if (last_word) chk_bad_q <= (stream.s_data != acc_q);
         else           acc_q     <= acc_q ^ stream.s_data;
      end
   end

   // Sticky checksum error; a new error outranks a simultaneous clear.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn)                          err_chk_q <= 1'b0;
      else if (state_q == CHK && chk_bad_q) err_chk_q <= 1'b1;
      else if (clr_err)                     err_chk_q <= 1'b0;
   end
`else
   assign chk_bad_q = 1'b0;
   assign err_chk_q = 1'b0;
`endif

   // Sticky sync/address errors; a new error outranks a simultaneous clear.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         err_sync_q <= 1'b0;
         err_addr_q <= 1'b0;
      end else begin
         if (state_q == IDLE && accept && !hdr_ok) err_sync_q <= 1'b1;
         else if (clr_err)                         err_sync_q <= 1'b0;
         if (hdr_take && idx_bad)                  err_addr_q <= 1'b1;
         else if (clr_err)                         err_addr_q <= 1'b0;
      end
   end

   // Registered handshake, busy and strobe derived from the upcoming state.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         strobe_q <= '0;
      end else begin
         ready_q  <= (state_next == IDLE) || (state_next == LOAD);
         busy_q   <= (state_next != IDLE);
         strobe_q <= (state_next == STROBE) ? strobe_sel : '0;
      end
   end

   // Saturating count of completed strobes.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) loaded_q <= '0;
      else if (state_q == STROBE && state_next == HOLD && loaded_q != 16'hFFFF)
         loaded_q <= loaded_q + 16'd1;
   end

   assign stream.s_ready = ready_q;
   assign frame_data     = data_q;
   assign frame_strobe   = strobe_q;
   assign busy           = busy_q;
   assign err_sync       = err_sync_q;
   assign err_addr       = err_addr_q;
   assign err_chk        = err_chk_q;
   assign frames_loaded  = loaded_q;

endmodule
